// File: rtl/sipo_pkg.sv
// sipo_pkg: shared definitions for the SIPO deserializer slice.
//   - bit_order_e : first-received-bit placement (MSB or LSB end of the word)
//   - PARITY_EN   : 1 when the build is made with SIPO_PARITY_EN defined
//   - frame_len() : bits per frame (data bits, plus one parity bit if enabled)
//   - cnt_width() : bit-counter width for a given frame length
// Optional feature macro: SIPO_PARITY_EN (trailing even-parity bit per frame).
package sipo_pkg;

  typedef enum logic {
    OrderLsbFirst = 1'b0,
    OrderMsbFirst = 1'b1
  } bit_order_e;

`ifdef SIPO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int unsigned frame_len(input int unsigned width, input bit parity);
    return parity ? width + 1 : width;
  endfunction

  // CNT_W = $clog2(FRAME_LEN); never below one bit.
  function automatic int unsigned cnt_width(input int unsigned flen);
    return (flen < 2) ? 1 : $clog2(flen);
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if: serial-side and word-side signals of the deserializer.
//   serial_in, shift_en, frame_clr : serial stream and framing controls
//   par_ready                      : consumer accepts par_out
//   par_out, par_valid             : holding register and its valid flag
//   busy, overrun, parity_err      : status
// Modports: slave (the deserializer), master (the driver/consumer side).
interface sipo_deserializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             serial_in;
  logic             shift_en;
  logic             frame_clr;
  logic             par_ready;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport slave (
    input  serial_in, shift_en, frame_clr, par_ready,
    output par_out, par_valid, busy, overrun, parity_err
  );

  modport master (
    output serial_in, shift_en, frame_clr, par_ready,
    input  par_out, par_valid, busy, overrun, parity_err
  );
endinterface

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: shift register plus bit counter for one frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   serial_in  : serial bit, consumed when shift_en=1
//   shift_en   : bit-valid qualifier
//   frame_clr  : synchronous abort of the partial frame (wins over shift_en)
//   busy       : bit counter is non-zero
//   done       : combinational strobe, the last bit of a frame is taken this cycle
//   word       : completed data word (valid with done), final data bit included
// With PARITY=1 the last bit of a frame is the parity bit; it is not shifted in,
// the parent picks it up from serial_in while done is high.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter bit          PARITY    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             shift_en,
  input  logic             frame_clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] word
);

  localparam int unsigned      FRAME_LEN = frame_len(WIDTH, PARITY);
  localparam int unsigned      CNT_W     = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);
  localparam bit_order_e       ORDER     = (MSB_FIRST != 0) ? OrderMsbFirst : OrderLsbFirst;

  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  always_comb begin
    sr_shift = (ORDER == OrderMsbFirst) ? {sr_q[WIDTH-2:0], serial_in}
                                        : {serial_in, sr_q[WIDTH-1:1]};
    last     = (cnt_q == CNT_LAST);
    done     = shift_en & ~frame_clr & last;
    // With parity the final bit is the parity bit, so sr already holds the data.
    word     = PARITY ? sr_q : sr_shift;
    busy     = (cnt_q != '0);
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (frame_clr) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_en) begin
      if (last) begin
        sr_d  = '0;
        cnt_d = '0;
      end else begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in parallel-out receiver with a registered output word.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sipo_deserializer_if.slave
//     serial_in/shift_en/frame_clr in, par_ready in,
//     par_out/par_valid/busy/overrun/parity_err out
// A completed word loads par_out on the edge that takes its last bit. If the
// holding register is still full and not being consumed, the word is dropped
// and the sticky overrun flag is set until frame_clr or reset.
// Optional feature macro: SIPO_PARITY_EN -- each frame carries a trailing
// even-parity bit and parity_err reports the check for the word in par_out.
// Without it parity_err is constant 0.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input logic                clk,
  input logic                rst_n,
  sipo_deserializer_if.slave bus
);

  logic             done;
  logic             busy;
  logic [WIDTH-1:0] word;
  logic             load;

  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             par_valid_q, par_valid_d;
  logic             overrun_q, overrun_d;

  sipo_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .PARITY   (PARITY_EN)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .serial_in(bus.serial_in),
    .shift_en (bus.shift_en),
    .frame_clr(bus.frame_clr),
    .busy     (busy),
    .done     (done),
    .word     (word)
  );

  // A completion is accepted if the holding register is free or freed this cycle.
  assign load = done & (~par_valid_q | bus.par_ready);

  always_comb begin
    par_out_d   = par_out_q;
    par_valid_d = par_valid_q;
    overrun_d   = overrun_q;
    if (bus.frame_clr) begin
      overrun_d = 1'b0;
    end
    if (load) begin
      par_out_d   = word;
      par_valid_d = 1'b1;
    end else if (done) begin
      overrun_d = 1'b1;
    end else if (par_valid_q && bus.par_ready) begin
      par_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SIPO_PARITY_EN
  logic parity_err_q, parity_err_d;

  // serial_in carries the parity bit in the completing cycle.
  always_comb begin
    parity_err_d = parity_err_q;
    if (load) begin
      parity_err_d = ^{word, bus.serial_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.par_out   = par_out_q;
  assign bus.par_valid = par_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed bench for sipo_deserializer (WIDTH=8).
// Two instances share all stimulus: u_msb (MSB_FIRST=1) and u_lsb (MSB_FIRST=0),
// so the LSB-first instance always expects the bit-reversed word.
// Build with SIPO_PARITY_EN to append the parity bit and run the parity checks.
module tb_sipo_deserializer;

`ifdef SIPO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(8)) bus_msb ();
  sipo_deserializer_if #(.WIDTH(8)) bus_lsb ();

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_msb)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_lsb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sin, input logic sen, input logic fclr, input logic rdy);
    bus_msb.serial_in = sin;  bus_lsb.serial_in = sin;
    bus_msb.shift_en  = sen;  bus_lsb.shift_en  = sen;
    bus_msb.frame_clr = fclr; bus_lsb.frame_clr = fclr;
    bus_msb.par_ready = rdy;  bus_lsb.par_ready = rdy;
  endtask

  // Sends w MSB-first (plus parity bit when enabled), gap idle cycles between bits.
  // par_ready is held at rdy, switched to rdy_last for the final bit edge.
  task automatic send_frame(input logic [7:0] w, input int gap, input logic rdy,
                            input logic rdy_last, input logic pflip);
    logic b;
    for (int k = 0; k < FL; k++) begin
      b = (k < 8) ? w[7-k] : (^w ^ pflip);
      drive(b, 1'b1, 1'b0, (k == FL - 1) ? rdy_last : rdy);
      tick();
      drive(1'b0, 1'b0, 1'b0, (k == FL - 1) ? rdy_last : rdy);
      if (k == 0) check("busy_first_bit", {31'd0, bus_msb.busy}, 32'd1);
      if (k == FL - 2) check("busy_before_last", {31'd0, bus_msb.busy}, 32'd1);
      if (k < FL - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          if (g == 0 && k == 3) check("busy_in_gap", {31'd0, bus_msb.busy}, 32'd1);
        end
      end
    end
    check("busy_after_last", {31'd0, bus_msb.busy}, 32'd0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_par_out", {24'd0, bus_msb.par_out}, 32'h0);
    check("rst_par_valid", {31'd0, bus_msb.par_valid}, 32'd0);
    check("rst_busy", {31'd0, bus_msb.busy}, 32'd0);
    check("rst_overrun", {31'd0, bus_msb.overrun}, 32'd0);
    check("rst_parity_err", {31'd0, bus_msb.parity_err}, 32'd0);

    // Reset mid-frame: 3 bits of A5 (1,0,1) then asynchronous reset.
    for (int k = 0; k < 3; k++) begin
      drive((k == 1) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("partial_busy", {31'd0, bus_msb.busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    check("midrst_busy", {31'd0, bus_msb.busy}, 32'd0);
    check("midrst_valid", {31'd0, bus_msb.par_valid}, 32'd0);
    check("midrst_par_out", {24'd0, bus_msb.par_out}, 32'h0);
    tick();
    rst_n = 1'b1;
    send_frame(8'h3C, 0, 1'b1, 1'b1, 1'b0);
    check("after_rst_par_out", {24'd0, bus_msb.par_out}, 32'h3C);
    check("after_rst_valid", {31'd0, bus_msb.par_valid}, 32'd1);
    tick();
    check("after_rst_consumed", {31'd0, bus_msb.par_valid}, 32'd0);

    // Continuous A5, par_ready=1.
    send_frame(8'hA5, 0, 1'b1, 1'b1, 1'b0);
    check("a5_par_out", {24'd0, bus_msb.par_out}, 32'hA5);
    check("a5_valid", {31'd0, bus_msb.par_valid}, 32'd1);
    check("a5_lsb_par_out", {24'd0, bus_lsb.par_out}, {24'd0, rev8(8'hA5)});
    check("a5_parity_err", {31'd0, bus_msb.parity_err}, 32'd0);
    tick();
    check("a5_valid_drop", {31'd0, bus_msb.par_valid}, 32'd0);

    // Gapped shift_en (every 3rd cycle) for 3C.
    send_frame(8'h3C, 2, 1'b1, 1'b1, 1'b0);
    check("gap_par_out", {24'd0, bus_msb.par_out}, 32'h3C);
    check("gap_valid", {31'd0, bus_msb.par_valid}, 32'd1);
    tick();
    check("gap_valid_drop", {31'd0, bus_msb.par_valid}, 32'd0);

    // Backpressure: 5A held, FF dropped.
    send_frame(8'h5A, 0, 1'b0, 1'b0, 1'b0);
    check("bp_first_par_out", {24'd0, bus_msb.par_out}, 32'h5A);
    check("bp_first_overrun", {31'd0, bus_msb.overrun}, 32'd0);
    send_frame(8'hFF, 0, 1'b0, 1'b0, 1'b0);
    check("bp_par_out", {24'd0, bus_msb.par_out}, 32'h5A);
    check("bp_valid", {31'd0, bus_msb.par_valid}, 32'd1);
    check("bp_overrun", {31'd0, bus_msb.overrun}, 32'd1);
    tick();
    check("bp_overrun_sticky", {31'd0, bus_msb.overrun}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("clr_overrun", {31'd0, bus_msb.overrun}, 32'd0);
    check("clr_valid_kept", {31'd0, bus_msb.par_valid}, 32'd1);
    check("clr_par_out_kept", {24'd0, bus_msb.par_out}, 32'h5A);
    check("clr_busy", {31'd0, bus_msb.busy}, 32'd0);

    // Drain, then load 11 and complete 22 while consuming 11.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("drain_valid", {31'd0, bus_msb.par_valid}, 32'd0);
    send_frame(8'h11, 0, 1'b0, 1'b0, 1'b0);
    check("hold_11", {24'd0, bus_msb.par_out}, 32'h11);
    send_frame(8'h22, 0, 1'b0, 1'b1, 1'b0);
    check("simul_par_out", {24'd0, bus_msb.par_out}, 32'h22);
    check("simul_valid", {31'd0, bus_msb.par_valid}, 32'd1);
    check("simul_overrun", {31'd0, bus_msb.overrun}, 32'd0);
    tick();
    check("simul_drop", {31'd0, bus_msb.par_valid}, 32'd0);

    // Bits 1,0,0,0,0,0,0,0: LSB-first instance yields 01.
    send_frame(8'h80, 0, 1'b1, 1'b1, 1'b0);
    check("lsb_par_out", {24'd0, bus_lsb.par_out}, 32'h01);
    check("msb_par_out_80", {24'd0, bus_msb.par_out}, 32'h80);
    tick();

`ifdef SIPO_PARITY_EN
    // A5 has four ones: parity bit 1 is wrong, 0 is right.
    send_frame(8'hA5, 0, 1'b1, 1'b1, 1'b1);
    check("par_bad", {31'd0, bus_msb.parity_err}, 32'd1);
    check("par_bad_out", {24'd0, bus_msb.par_out}, 32'hA5);
    tick();
    check("par_err_holds", {31'd0, bus_msb.parity_err}, 32'd1);
    send_frame(8'hA5, 0, 1'b1, 1'b1, 1'b0);
    check("par_good", {31'd0, bus_msb.parity_err}, 32'd0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
